key_schedule_ctrl: RTL and testbench

Sequencer that drives the single-step AES key-expansion unit to build the full round-key set for AES-128 or AES-256 from a cipher key, one expansion step at a time. It stores every round key in an internal 15-entry register file and exposes them to the cipher round datapath through a registered read port. It sits between the host key-load interface and the expansion unit, and owns that unit's inputs exclusively.

---
 rtl/key_schedule_ctrl.sv | 126 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128/256 round-key schedule sequencer.
// Drives a one-step expansion unit and holds all round keys for readback.
module key_schedule_ctrl #(
  parameter int KEY_WIDTH = 128,
  parameter int WATCHDOG  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   key_len,
  input  logic [2*KEY_WIDTH-1:0] cipher_key,
  output logic [KEY_WIDTH-1:0]   exp_key,
  output logic [KEY_WIDTH-1:0]   exp_prev_key,
  output logic                   exp_key_len,
  output logic                   exp_flip,
  output logic [3:0]             exp_rnum,
  output logic                   exp_valid_in,
  input  logic                   exp_valid_out,
  input  logic [KEY_WIDTH-1:0]   exp_round_key,
  input  logic [3:0]             rd_addr,
  output logic [KEY_WIDTH-1:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   keys_valid,
  output logic                   error
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [KEY_WIDTH-1:0] rk [0:14];
  logic                 kl;
  logic [3:0]           j;
  logic [3:0]           wcnt;
  logic                 accept;
  logic                 timeout;
  logic [3:0]           last;

  assign accept  = (state == IDLE) && start;
  assign timeout = (wcnt == 4'(WATCHDOG - 1));
  assign last    = kl ? 4'd14 : 4'd10;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    exp_key      = '0;
    exp_prev_key = '0;
    exp_key_len  = 1'b0;
    exp_flip     = 1'b0;
    exp_rnum     = 4'd0;
    exp_valid_in = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = ISSUE;
      ISSUE: begin
        state_n      = WAIT;
        exp_valid_in = 1'b1;
        exp_key_len  = kl;
        exp_key      = rk[j - 4'd1];
        if (kl) begin
          exp_prev_key = rk[j - 4'd2];
          // even steps rotate+Rcon, odd steps are SubWord only
          exp_flip     = ~j[0];
          exp_rnum     = j[0] ? 4'd0 : {1'b0, j[3:1]} - 4'd1;
        end else begin
          exp_flip = 1'b1;
          exp_rnum = j - 4'd1;
        end
      end
      WAIT: begin
        if (exp_valid_out) state_n = (j == last) ? DONE : ISSUE;
        else if (timeout)  state_n = IDLE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) rk[i] <= '0;
      kl         <= 1'b0;
      j          <= 4'd0;
      wcnt       <= 4'd0;
      keys_valid <= 1'b0;
      error      <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (accept) begin
        kl         <= key_len;
        rk[0]      <= cipher_key[2*KEY_WIDTH-1:KEY_WIDTH];
        if (key_len) rk[1] <= cipher_key[KEY_WIDTH-1:0];
        keys_valid <= 1'b0;
        error      <= 1'b0;
        j          <= key_len ? 4'd2 : 4'd1;
      end
      if (state == ISSUE) wcnt <= 4'd0;
      if (state == WAIT) begin
        if (exp_valid_out) begin
          rk[j] <= exp_round_key;
          if (j != last) j <= j + 4'd1;
        end else if (timeout) begin
          error <= 1'b1;
        end else begin
          wcnt <= wcnt + 4'd1;
        end
      end
      if (state == DONE) keys_valid <= 1'b1;
      // a read racing an accepted start sees an empty schedule
      if (keys_valid && !accept && rd_addr <= last) rd_data <= rk[rd_addr];
      else                                          rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a behavioural AES expansion-step model.
// Reads and expansion steps are checked against queued expectations.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         key_len = 1'b0;
  logic [255:0] cipher_key = '0;
  logic [127:0] exp_key;
  logic [127:0] exp_prev_key;
  logic         exp_key_len;
  logic         exp_flip;
  logic [3:0]   exp_rnum;
  logic         exp_valid_in;
  logic         exp_valid_out;
  logic [127:0] exp_round_key;
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_data;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         error;

  key_schedule_ctrl #(.KEY_WIDTH(128), .WATCHDOG(4)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len),
    .cipher_key(cipher_key), .exp_key(exp_key),
    .exp_prev_key(exp_prev_key), .exp_key_len(exp_key_len),
    .exp_flip(exp_flip), .exp_rnum(exp_rnum),
    .exp_valid_in(exp_valid_in), .exp_valid_out(exp_valid_out),
    .exp_round_key(exp_round_key), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .keys_valid(keys_valid), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int checks = 0;
  int passed = 0;
  int stall_step = 0;
  int step_cnt = 0;
  logic [127:0] sb [$];
  logic [260:0] enc_q [$];
  logic [127:0] exp_rk [0:14];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    repeat (254) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
           {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] one;
    one = 8'h01;
    if (r < 4'd8) return one << r;
    return (r == 4'd8) ? 8'h1b : 8'h36;
  endfunction

  function automatic logic [127:0] xstep(input logic [127:0] k,
    input logic [127:0] p, input logic kln, input logic fl,
    input logic [3:0] rn);
    logic [31:0] t, w0, w1, w2, w3;
    logic [127:0] b;
    t = k[31:0];
    if (fl) t = {t[23:0], t[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    if (fl) t = t ^ {rcon(rn), 24'h0};
    b = kln ? p : k;
    w0 = b[127:96] ^ t;
    w1 = b[95:64] ^ w0;
    w2 = b[63:32] ^ w1;
    w3 = b[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic expand(input logic kln, input logic [255:0] ck);
    for (int i = 0; i < 15; i++) exp_rk[i] = '0;
    exp_rk[0] = ck[255:128];
    if (kln) begin
      exp_rk[1] = ck[127:0];
      for (int i = 2; i < 15; i++)
        exp_rk[i] = xstep(exp_rk[i-1], exp_rk[i-2], 1'b1, (i % 2) == 0,
                          (i % 2) == 0 ? 4'(i / 2 - 1) : 4'd0);
    end else begin
      for (int i = 1; i < 11; i++)
        exp_rk[i] = xstep(exp_rk[i-1], '0, 1'b0, 1'b1, 4'(i - 1));
    end
  endtask

  // queue the expected expansion-unit requests for an AES-256 build
  task automatic push_enc256();
    enc_q.delete();
    for (int i = 2; i < 15; i++)
      enc_q.push_back({(i % 2) == 0, (i % 2) == 0 ? 4'(i / 2 - 1) : 4'd0,
                       exp_rk[i-1], exp_rk[i-2]});
  endtask

  // expansion unit: registered, one cycle latency, optional stall
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_valid_out <= 1'b0;
      exp_round_key <= '0;
      step_cnt      <= 0;
    end else begin
      exp_valid_out <= 1'b0;
      if (exp_valid_in) begin
        step_cnt <= step_cnt + 1;
        if (step_cnt + 1 != stall_step) begin
          exp_valid_out <= 1'b1;
          exp_round_key <= xstep(exp_key, exp_prev_key, exp_key_len,
                                 exp_flip, exp_rnum);
        end
      end else if (start && !busy) begin
        step_cnt <= 0;
      end
    end
  end

  task automatic kick(input logic kln, input logic [255:0] ck);
    key_len    = kln;
    cipher_key = ck;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    got = {busy, done, keys_valid, error, exp_valid_in, exp_flip,
           |rd_data};
    checks++;
    if (got !== 7'd0) $display("FAIL reset_flags: got %b want 0", got);
    else passed++;
    checks++;
    if ({exp_key, exp_prev_key} !== 256'd0)
      $display("FAIL reset_exp_key: got %h want 0", exp_key);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, keys_valid, error, rd_data} !== '0)
      $display("FAIL reset_idle: busy %b kv %b err %b rd %h", busy,
               keys_valid, error, rd_data);
    else passed++;
  endtask

  task automatic test_aes128();
    int c;
    logic [3:0]   a [6];
    logic [127:0] w [6];
    logic [127:0] e;
    expand(1'b0, K128);
    kick(1'b0, K128);
    checks++;
    if (busy !== 1'b1) $display("FAIL a128_busy: got %b want 1", busy);
    else passed++;
    run_to_done(c);
    checks++;
    if (c !== 21) $display("FAIL a128_done_cycle: got %0d want 21", c);
    else passed++;
    checks++;
    if (keys_valid !== 1'b0)
      $display("FAIL a128_kv_at_done: got %b want 0", keys_valid);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({keys_valid, busy, done} !== 3'b100)
      $display("FAIL a128_after_done: got %b want 100",
               {keys_valid, busy, done});
    else passed++;
    a = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd5, 4'd15};
    w = '{K128[255:128], 128'ha0fafe1788542cb123a339392a6c7605,
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0, exp_rk[5], 128'h0};
    for (int i = 0; i < 6; i++) begin
      rd_addr = a[i];
      sb.push_back(w[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_data !== e)
        $display("FAIL a128_rd%0d: got %h want %h", a[i], rd_data, e);
      else passed++;
    end
  endtask

  task automatic test_aes256_steps();
    int c;
    int b2b;
    int extra;
    logic prevv;
    logic [260:0] x;
    logic [3:0]   a [4];
    logic [127:0] w [4];
    logic [127:0] e;
    expand(1'b1, K256);
    push_enc256();
    kick(1'b1, K256);
    c = 1; b2b = 0; extra = 0; prevv = 1'b0;
    while (done !== 1'b1 && c < 80) begin
      if (exp_valid_in === 1'b1) begin
        if (prevv) b2b++;
        if (enc_q.size() == 0) extra++;
        else begin
          x = enc_q.pop_front();
          checks++;
          if ({exp_flip, exp_rnum, exp_key, exp_prev_key} !== x)
            $display("FAIL a256_step: got fl %b rn %0d want fl %b rn %0d",
                     exp_flip, exp_rnum, x[260], x[259:256]);
          else passed++;
        end
      end
      prevv = exp_valid_in;
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 27) $display("FAIL a256_done_cycle: got %0d want 27", c);
    else passed++;
    checks++;
    if (b2b + extra + enc_q.size() !== 0)
      $display("FAIL a256_step_count: got b2b %0d extra %0d left %0d want 0",
               b2b, extra, enc_q.size());
    else passed++;
    @(posedge clk); #1;
    a = '{4'd1, 4'd2, 4'd14, 4'd15};
    w = '{128'h1f352c073b6108d72d9810a30914dff4,
          128'h9ba354118e6925afa51a8b5f2067fcde,
          128'hfe4890d1e6188d0b046df344706c631e, 128'h0};
    for (int i = 0; i < 4; i++) begin
      rd_addr = a[i];
      sb.push_back(w[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_data !== e)
        $display("FAIL a256_rd%0d: got %h want %h", a[i], rd_data, e);
      else passed++;
    end
  endtask

  task automatic test_read_on_start();
    logic [127:0] e;
    rd_addr = 4'd1;
    sb.push_back(128'h0);
    kick(1'b0, K128);
    e = sb.pop_front();
    checks++;
    if (rd_data !== e)
      $display("FAIL rd_on_start: got %h want %h", rd_data, e);
    else passed++;
    run_to_done(e[31:0]);
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog();
    int c;
    int c2;
    logic [127:0] e;
    stall_step = 5;
    kick(1'b0, K128);
    c = 1;
    while (error !== 1'b1 && c < 80) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 14) $display("FAIL wd_error_cycle: got %0d want 14", c);
    else passed++;
    checks++;
    if ({busy, keys_valid, exp_valid_in} !== 3'b000)
      $display("FAIL wd_idle: got %b want 000",
               {busy, keys_valid, exp_valid_in});
    else passed++;
    rd_addr = 4'd0;
    sb.push_back(128'h0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (rd_data !== e) $display("FAIL wd_rd0: got %h want %h", rd_data, e);
    else passed++;
    stall_step = 0;
    expand(1'b0, K128);
    kick(1'b0, K128);
    checks++;
    if ({error, busy} !== 2'b01)
      $display("FAIL wd_restart: got err %b busy %b want 0 1", error, busy);
    else passed++;
    run_to_done(c2);
    checks++;
    if (c2 !== 21) $display("FAIL wd_rebuild_done: got %0d want 21", c2);
    else passed++;
    @(posedge clk); #1;
    rd_addr = 4'd7;
    sb.push_back(exp_rk[7]);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (rd_data !== e) $display("FAIL wd_rd7: got %h want %h", rd_data, e);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int c;
    logic [127:0] e;
    kick(1'b0, K128);
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_valid_in !== 1'b1)
      $display("FAIL mr_step6_issue: got %b want 1", exp_valid_in);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, keys_valid, error, exp_valid_in, |exp_key,
         |exp_rnum, |rd_data} !== 8'd0)
      $display("FAIL mr_async_clear: busy %b vin %b key %h", busy,
               exp_valid_in, exp_key);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    rd_addr = 4'd0;
    sb.push_back(128'h0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (rd_data !== e) $display("FAIL mr_rd0: got %h want %h", rd_data, e);
    else passed++;
    expand(1'b0, K128);
    kick(1'b0, K128);
    run_to_done(c);
    checks++;
    if (c !== 21) $display("FAIL mr_rebuild_done: got %0d want 21", c);
    else passed++;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      rd_addr = 4'(i);
      sb.push_back(exp_rk[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_data !== e)
        $display("FAIL mr_rd%0d: got %h want %h", i, rd_data, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int extra;
    logic [260:0] x;
    logic [127:0] e;
    expand(1'b1, K256);
    push_enc256();
    key_len    = 1'b1;
    cipher_key = K256;
    start      = 1'b1;
    @(posedge clk); #1;
    c = 1; extra = 0;
    while (done !== 1'b1 && c < 80) begin
      if (exp_valid_in === 1'b1) begin
        if (enc_q.size() == 0) extra++;
        else begin
          x = enc_q.pop_front();
          checks++;
          if ({exp_flip, exp_rnum, exp_key, exp_prev_key} !== x)
            $display("FAIL b2b_a256_step: got key %h want %h", exp_key,
                     x[255:128]);
          else passed++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 27 || extra + enc_q.size() != 0)
      $display("FAIL b2b_a256_done: got cyc %0d left %0d want 27 0", c,
               enc_q.size() + extra);
    else passed++;
    key_len    = 1'b0;
    cipher_key = K128;
    @(posedge clk); #1;
    checks++;
    if ({busy, keys_valid} !== 2'b01)
      $display("FAIL b2b_gap: got busy %b kv %b want 0 1", busy, keys_valid);
    else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({exp_valid_in, exp_key_len, exp_key} !== {2'b10, K128[255:128]})
      $display("FAIL b2b_second_issue: got vin %b key %h", exp_valid_in,
               exp_key);
    else passed++;
    run_to_done(c);
    checks++;
    if (c !== 21) $display("FAIL b2b_a128_done: got %0d want 21", c);
    else passed++;
    @(posedge clk); #1;
    expand(1'b0, K128);
    for (int i = 0; i < 12; i++) begin
      rd_addr = 4'(i);
      sb.push_back(i < 11 ? exp_rk[i] : 128'h0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (rd_data !== e)
        $display("FAIL b2b_rd%0d: got %h want %h", i, rd_data, e);
      else passed++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_aes128();
    test_aes256_steps();
    test_read_on_start();
    test_watchdog();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
